// File: rtl/step_gen.sv
// Step-pulse generator: debounced push-button single steps or a free-running
// auto-step prescaler, producing a one-cycle enable for a downstream counter.
module step_gen #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned DIV_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  input  logic             auto_en,
  input  logic [DIV_W-1:0] div,
  output logic             step,
  output logic             held,
  output logic             err
);

  localparam int unsigned DC_W = $clog2(DB_CYCLES) + 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    PRESSED = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t            state;
  logic [DC_W-1:0]   dcnt;
  logic [DIV_W-1:0]  pcnt;
  logic              sync_q;
  logic              btn_s;
  logic              press_fire_c;
  logic              auto_fire_c;

  // Two-flop synchronizer for the raw button level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sync_q <= btn_in;
      btn_s  <= sync_q;
    end
  end

  // A press is accepted on the edge that moves WAIT_HI -> PRESSED
  assign press_fire_c = (state == WAIT_HI) && btn_s && (dcnt == DC_LAST);
  assign auto_fire_c  = auto_en && (pcnt >= div);

  // Debounce FSM; held tracks PRESSED/WAIT_LO as a registered flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      dcnt  <= '0;
      held  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= WAIT_HI;
            dcnt  <= '0;
          end
        end
        WAIT_HI: begin
          if (!btn_s) begin
            state <= IDLE;
          end else if (dcnt == DC_LAST) begin
            state <= PRESSED;
            held  <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state <= WAIT_LO;
            dcnt  <= '0;
          end
        end
        WAIT_LO: begin
          if (btn_s) begin
            state <= PRESSED;
          end else if (dcnt == DC_LAST) begin
            state <= IDLE;
            held  <= 1'b0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          held  <= 1'b0;
        end
      endcase
    end
  end

  // Prescaler: >= compare lets a lowered div fire at once without wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
    end else if (!auto_en) begin
      pcnt <= '0;
    end else if (auto_fire_c) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // auto_en selects the step source; a press in auto mode is flagged instead
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step <= 1'b0;
      err  <= 1'b0;
    end else begin
      step <= auto_en ? auto_fire_c : press_fire_c;
      err  <= auto_en && press_fire_c;
    end
  end

endmodule
